gb_bus_peek: RTL and testbench

Read bridge between the Nios II PIO pair (`address_export` out, `din_export` in) and the Game Boy memory bus. It watches the 16-bit address the Nios drives and issues a single-byte read to the Game Boy memory system (ROM/VRAM/WRAM mux) over a req/ack handshake. It returns the byte on the 8-bit data PIO, letting debug and loader software peek Game Boy memory. It sits directly downstream of `address_export` and upstream of `din_export`.

---
 rtl/gb_bus_peek_if.sv | 30 +++
 rtl/gb_bus_peek.sv | 146 ++++++++++++++
 tb/tb_gb_bus_peek.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_bus_peek_if.sv
// gb_bus_peek_if: single-byte read handshake between the peek bridge and the
// Game Boy memory mux (ROM/VRAM/WRAM).
//   mem_req   : level read request, held until mem_ack
//   mem_addr  : read address, stable while mem_req=1
//   mem_rdata : read data, valid in the mem_ack cycle
//   mem_ack   : one-cycle completion pulse
// Modports: master = bridge side, slave = memory side.
interface gb_bus_peek_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/gb_bus_peek.sv
// gb_bus_peek: read bridge from the Nios PIO pair to the Game Boy memory bus.
// Whenever the peek address from the Nios changes (or once after reset), one
// byte is read over a req/ack handshake and presented on din_export.
// Address changes while a read is in flight are coalesced: only the value seen
// on return to IDLE is fetched.
//
// Ports:
//   clk_clk        : system clock, rising edge
//   reset_reset_n  : synchronous active-low reset
//   address_export : peek address from the Nios PIO
//   din_export     : last completed read byte, to the Nios PIO
//   mem            : gb_bus_peek_if.master read handshake (req/addr/rdata/ack)
//   busy           : high while a read is outstanding (equals mem_req)
//   timeout_flag   : sticky, set when a read is abandoned
//
// Optional feature: define GB_PEEK_TIMEOUT_EN to abandon a read after
// TIMEOUT_CYCLES unacked WAIT cycles, returning FILL_BYTE. Without it, WAIT
// waits indefinitely and timeout_flag is tied low.
module gb_bus_peek #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  FILL_BYTE      = 8'hFF
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [15:0]          address_export,
  output logic [7:0]           din_export,
  gb_bus_peek_if.master        mem,
  output logic                 busy,
  output logic                 timeout_flag
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  // Elaboration-time parameter sanity check.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || $bits(FILL_BYTE) != DW) begin : g_bad_param
    $error("gb_bus_peek: TIMEOUT_CYCLES must be 2..65535");
  end

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          pending_q, pending_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          req_q, req_d;
  logic          busy_q;
  logic [DW-1:0] din_q, din_d;

`ifdef GB_PEEK_TIMEOUT_EN
  localparam int unsigned CW = 16;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          tflag_q, tflag_d;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pending_d  = pending_q;
    mem_addr_d = mem_addr_q;
    req_d      = req_q;
    din_d      = din_q;
`ifdef GB_PEEK_TIMEOUT_EN
    tcnt_d     = tcnt_q;
    tflag_d    = tflag_q;
`endif
    unique case (state_q)
      IDLE: begin
        // pending forces one fetch after reset even if the address matches.
        if (pending_q || (address_export != addr_q)) begin
          addr_d     = address_export;
          mem_addr_d = address_export;
          req_d      = 1'b1;
          pending_d  = 1'b0;
`ifdef GB_PEEK_TIMEOUT_EN
          tcnt_d     = '0;
`endif
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // Ack takes priority over a simultaneous timeout.
        if (mem.mem_ack) begin
          din_d   = mem.mem_rdata;
          req_d   = 1'b0;
          state_d = IDLE;
        end
`ifdef GB_PEEK_TIMEOUT_EN
        else if (tcnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          din_d   = FILL_BYTE;
          tflag_d = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          tcnt_d  = tcnt_q + CW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      pending_q  <= 1'b1;
      mem_addr_q <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      din_q      <= '0;
`ifdef GB_PEEK_TIMEOUT_EN
      tcnt_q     <= '0;
      tflag_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pending_q  <= pending_d;
      mem_addr_q <= mem_addr_d;
      req_q      <= req_d;
      busy_q     <= req_d;
      din_q      <= din_d;
`ifdef GB_PEEK_TIMEOUT_EN
      tcnt_q     <= tcnt_d;
      tflag_q    <= tflag_d;
`endif
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = mem_addr_q;
  assign din_export   = din_q;
  assign busy         = busy_q;
`ifdef GB_PEEK_TIMEOUT_EN
  assign timeout_flag = tflag_q;
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_gb_bus_peek.sv
// tb_gb_bus_peek: directed bench for gb_bus_peek with a transaction-level
// reference model compared every cycle plus hand-computed literal checks.
module tb_gb_bus_peek;
  localparam int unsigned TO = 4;
`ifdef GB_PEEK_TIMEOUT_EN
  localparam int ACK_DLY = 2;
`else
  localparam int ACK_DLY = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr_in = 16'h0000;
  logic [7:0]  din;
  logic        busy;
  logic        tflag;

  gb_bus_peek_if bus();

  gb_bus_peek #(.TIMEOUT_CYCLES(TO), .FILL_BYTE(8'hFF)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .address_export (addr_in),
    .din_export     (din),
    .mem            (bus.master),
    .busy           (busy),
    .timeout_flag   (tflag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Reference model: one outstanding read at a time, fetch on address change.
  logic        m_out;
  logic        m_first;
  logic [15:0] m_last;
  logic [15:0] m_addr;
  logic [7:0]  m_din;
  logic        m_flag;
  int          m_cnt;
  logic [15:0] m_log[$];
  logic [15:0] d_log[$];
  logic        d_prev_req = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_out = 1'b0; m_first = 1'b1; m_last = 16'h0; m_addr = 16'h0;
      m_din = 8'h00; m_flag = 1'b0; m_cnt = 0;
    end else if (!m_out) begin
      if (m_first || addr_in != m_last) begin
        m_last = addr_in; m_addr = addr_in; m_out = 1'b1; m_first = 1'b0; m_cnt = 0;
        m_log.push_back(addr_in);
      end
    end else if (bus.mem_ack) begin
      m_din = bus.mem_rdata; m_out = 1'b0;
    end else begin
`ifdef GB_PEEK_TIMEOUT_EN
      m_cnt++;
      if (m_cnt == int'(TO)) begin
        m_din = 8'hFF; m_flag = 1'b1; m_out = 1'b0;
      end
`endif
    end
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("model.mem_req", 16'(bus.mem_req), 16'(m_out));
    check("model.busy", 16'(busy), 16'(m_out));
    check("model.mem_addr", bus.mem_addr, m_addr);
    check("model.din", 16'(din), 16'(m_din));
    check("model.timeout_flag", 16'(tflag), 16'(m_flag));
  endtask

  // Advance one cycle: compare at the falling edge, resume 2ns after rising.
  task automatic step();
    @(negedge clk);
    if (check_en) begin
      cmp_model();
      if (bus.mem_req === 1'b1 && !d_prev_req) d_log.push_back(bus.mem_addr);
      d_prev_req = (bus.mem_req === 1'b1);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish by 100000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'h00;
    rst_n = 1'b0;
    addr_in = 16'h0000;
    @(posedge clk); #2;
    check_en = 1'b1;
    step(); step();
    check("reset.busy", 16'(busy), 16'h0);
    check("reset.din", 16'(din), 16'h00);
    check("reset.mem_req", 16'(bus.mem_req), 16'h0);
    check("reset.flag", 16'(tflag), 16'h0);

    // First read after reset release, ack in first WAIT cycle.
    rst_n = 1'b1;
    step();
    check("s1.req", 16'(bus.mem_req), 16'h1);
    check("s1.addr", bus.mem_addr, 16'h0000);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h31;
    step();
    bus.mem_ack = 1'b0;
    check("s1.din", 16'(din), 16'h31);
    check("s1.busy", 16'(busy), 16'h0);

    // Delayed ack: address held, data only changes on the ack edge.
    addr_in = 16'h0104;
    step();
    for (int i = 0; i < ACK_DLY; i++) begin
      check("s2.addr", bus.mem_addr, 16'h0104);
      check("s2.din_hold", 16'(din), 16'h31);
      step();
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hCE;
    check("s2.din_pre", 16'(din), 16'h31);
    step();
    bus.mem_ack = 1'b0;
    check("s2.din", 16'(din), 16'hCE);
    check("s2.busy", 16'(busy), 16'h0);

    // Address sweep during a read is coalesced.
    addr_in = 16'h8000;
    step();
    addr_in = 16'h8001;
    step();
    addr_in = 16'h8002;
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h11;
    step();
    bus.mem_ack = 1'b0;
    check("s3.din1", 16'(din), 16'h11);
    check("s3.gap", 16'(bus.mem_req), 16'h0);
    step();
    check("s3.req2", 16'(bus.mem_req), 16'h1);
    check("s3.addr2", bus.mem_addr, 16'h8002);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h22;
    step();
    bus.mem_ack = 1'b0;
    check("s3.din2", 16'(din), 16'h22);
    step(); step();
    check("s3.quiet", 16'(bus.mem_req), 16'h0);

    // Stray ack in IDLE is ignored.
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h55;
    step();
    bus.mem_ack = 1'b0;
    check("s4.din", 16'(din), 16'h22);
    check("s4.req", 16'(bus.mem_req), 16'h0);
    step();
    check("s4.req2", 16'(bus.mem_req), 16'h0);

`ifdef GB_PEEK_TIMEOUT_EN
    // Ack on the last allowed WAIT cycle wins over the timeout.
    addr_in = 16'h2000;
    step(); step(); step(); step();
    check("s5.req_w4", 16'(bus.mem_req), 16'h1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5A;
    step();
    bus.mem_ack = 1'b0;
    check("s5.ack_din", 16'(din), 16'h5A);
    check("s5.ack_flag", 16'(tflag), 16'h0);
    check("s5.ack_req", 16'(bus.mem_req), 16'h0);
    // No ack: abandoned after 4 WAIT cycles.
    addr_in = 16'h2001;
    step();
    for (int i = 0; i < 3; i++) begin
      check("s5.to_req", 16'(bus.mem_req), 16'h1);
      step();
    end
    check("s5.to_req_w4", 16'(bus.mem_req), 16'h1);
    step();
    check("s5.to_req_drop", 16'(bus.mem_req), 16'h0);
    check("s5.to_busy", 16'(busy), 16'h0);
    check("s5.to_din", 16'(din), 16'hFF);
    check("s5.to_flag", 16'(tflag), 16'h1);
    step(); step(); step();
    check("s5.flag_sticky", 16'(tflag), 16'h1);
    check("s5.idle", 16'(bus.mem_req), 16'h0);
`else
    // Without timeout support WAIT holds indefinitely.
    addr_in = 16'h1234;
    step();
    repeat (80) step();
    check("s5.req_hold", 16'(bus.mem_req), 16'h1);
    check("s5.busy_hold", 16'(busy), 16'h1);
    check("s5.addr_hold", bus.mem_addr, 16'h1234);
    check("s5.din_hold", 16'(din), 16'h22);
    check("s5.flag", 16'(tflag), 16'h0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h77;
    step();
    bus.mem_ack = 1'b0;
    check("s5.din", 16'(din), 16'h77);
    check("s5.flag2", 16'(tflag), 16'h0);
`endif

    // Reset in the 3rd WAIT cycle; a late ack must be ignored.
    addr_in = 16'h4567;
    step(); step(); step();
    check("s6.req_w3", 16'(bus.mem_req), 16'h1);
    rst_n = 1'b0;
    step();
    check("s6.rst_req", 16'(bus.mem_req), 16'h0);
    check("s6.rst_din", 16'(din), 16'h00);
    check("s6.rst_flag", 16'(tflag), 16'h0);
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hAA;
    step();
    bus.mem_ack = 1'b0;
    check("s6.late_din", 16'(din), 16'h00);
    check("s6.fresh_req", 16'(bus.mem_req), 16'h1);
    check("s6.fresh_addr", bus.mem_addr, 16'h4567);
    step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h3C;
    step();
    bus.mem_ack = 1'b0;
    check("s6.din", 16'(din), 16'h3C);
    step(); step();

    // Fetch history: model versus DUT, plus pinned entries.
    check("log.size", 16'(d_log.size()), 16'(m_log.size()));
    for (int i = 0; i < m_log.size() && i < d_log.size(); i++)
      check("log.entry", d_log[i], m_log[i]);
    check("log.first", (d_log.size() > 0) ? d_log[0] : 16'hDEAD, 16'h0000);
    check("log.third", (d_log.size() > 2) ? d_log[2] : 16'hDEAD, 16'h8000);
    check("log.fourth", (d_log.size() > 3) ? d_log[3] : 16'hDEAD, 16'h8002);
    begin
      int n8001;
      n8001 = 0;
      foreach (d_log[i]) if (d_log[i] == 16'h8001) n8001++;
      check("log.no_8001", 16'(n8001), 16'h0);
    end
`ifdef GB_PEEK_TIMEOUT_EN
    check("log.count", 16'(d_log.size()), 16'd8);
`else
    check("log.count", 16'(d_log.size()), 16'd7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
